// File: rtl/rm_lane_accumulator.sv
// Per-lane saturating event accumulator downstream of the RM event router.
// Two stages: registered per-lane popcount, then counter/hit/sat update with a single-lane read port.
module rm_lane_accumulator #(
   parameter int NUM_LANES  = 5,
   parameter int NUM_EVENTS = 10,
   parameter int CNT_WIDTH  = 32,
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
   localparam int IW = $clog2(NUM_EVENTS + 1)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   en_i,
   input  logic [NUM_EVENTS-1:0][NUM_LANES-1:0]   lane_vector_i,
   input  logic [NUM_LANES-1:0]                   lane_reset_i,
   input  logic [NUM_LANES-1:0][CNT_WIDTH-1:0]    threshold_i,
   input  logic [NUM_LANES-1:0]                   hit_clr_i,
   output logic [NUM_LANES-1:0]                   hit_o,
   output logic [NUM_LANES-1:0]                   sat_o,
   input  logic                                   rd_req_i,
   input  logic [LW-1:0]                          rd_lane_i,
   input  logic                                   rd_clear_i,
   output logic                                   rd_valid_o,
   output logic [CNT_WIDTH-1:0]                   rd_data_o,
   output logic                                   rd_err_o
);

   localparam int                   SW      = CNT_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   function automatic logic [IW-1:0] lane_popcount(
      input logic [NUM_EVENTS-1:0][NUM_LANES-1:0] vec,
      input int                                   lane
   );
      logic [IW-1:0] sum;
      sum = '0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
         sum = sum + IW'(vec[e][lane]);
      end
      return sum;
   endfunction

   logic [NUM_LANES-1:0][IW-1:0]        inc_q, inc_d;
   logic [NUM_LANES-1:0]                rst_q, rst_d;
   logic [NUM_LANES-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [NUM_LANES-1:0]                hit_q, hit_d;
   logic [NUM_LANES-1:0]                sat_q, sat_d;
   logic                                rd_valid_q, rd_valid_d;
   logic [CNT_WIDTH-1:0]                rd_data_q, rd_data_d;
   logic                                rd_err_q, rd_err_d;

   // Stage 1: per-lane event count, gated by the accumulate enable.
   always_comb begin
      inc_d = '0;
      rst_d = lane_reset_i;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (en_i) begin
            inc_d[l] = lane_popcount(lane_vector_i, l);
         end else begin
            inc_d[l] = '0;
         end
      end
   end

   // Stage 2: lane reset beats read-clear beats saturating accumulation.
   always_comb begin
      logic [SW-1:0] sum_s;
      logic          rdclr_s;
      logic          hit_set_s;
      cnt_d     = cnt_q;
      hit_d     = hit_q;
      sat_d     = sat_q;
      sum_s     = '0;
      rdclr_s   = 1'b0;
      hit_set_s = 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
         sum_s   = {1'b0, cnt_q[l]} + SW'(inc_q[l]);
         rdclr_s = rd_req_i & rd_clear_i & (rd_lane_i == LW'(l));
         if (rst_q[l]) begin
            cnt_d[l] = '0;
            sat_d[l] = 1'b0;
         end else if (rdclr_s) begin
            cnt_d[l] = CNT_WIDTH'(inc_q[l]);
            sat_d[l] = 1'b0;
         end else if (sum_s[CNT_WIDTH]) begin
            cnt_d[l] = CNT_MAX;
            sat_d[l] = 1'b1;
         end else begin
            cnt_d[l] = sum_s[CNT_WIDTH-1:0];
            sat_d[l] = sat_q[l];
         end
         // Edge-detected crossing only; a counter already above threshold never re-fires.
         hit_set_s = !rst_q[l] && (threshold_i[l] != '0) &&
                     (cnt_q[l] < threshold_i[l]) && (cnt_d[l] >= threshold_i[l]);
         if (rst_q[l]) begin
            hit_d[l] = 1'b0;
         end else if (hit_set_s) begin
            hit_d[l] = 1'b1;
         end else if (hit_clr_i[l]) begin
            hit_d[l] = 1'b0;
         end else begin
            hit_d[l] = hit_q[l];
         end
      end
   end

   // Read port: returns the pre-update counter of the requested lane.
   always_comb begin
      rd_valid_d = rd_req_i;
      rd_err_d   = 1'b0;
      rd_data_d  = '0;
      if (rd_req_i) begin
         if ({1'b0, rd_lane_i} >= (LW + 1)'(NUM_LANES)) begin
            rd_err_d = 1'b1;
         end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
               if (rd_lane_i == LW'(l)) begin
                  rd_data_d = cnt_q[l];
               end else begin
                  rd_data_d = rd_data_d;
               end
            end
         end
      end else begin
         rd_err_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inc_q      <= '0;
         rst_q      <= '0;
         cnt_q      <= '0;
         hit_q      <= '0;
         sat_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         inc_q      <= inc_d;
         rst_q      <= rst_d;
         cnt_q      <= cnt_d;
         hit_q      <= hit_d;
         sat_q      <= sat_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign hit_o      = hit_q;
   assign sat_o      = sat_q;
   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_data_q;
   assign rd_err_o   = rd_err_q;

endmodule

// File: tb/tb_rm_lane_accumulator.sv
// Scoreboard bench for rm_lane_accumulator: directed scenarios followed by random traffic,
// checked against a cycle-level arithmetic model of the lane counters.
module tb_rm_lane_accumulator;

   localparam int NL   = 5;
   localparam int NE   = 10;
   localparam int CW   = 8;
   localparam int LW   = 3;
   localparam int CMAX = 255;

   logic                      clk_i = 1'b0;
   logic                      rst_i;
   logic                      en_i;
   logic [NE-1:0][NL-1:0]     lane_vector_i;
   logic [NL-1:0]             lane_reset_i;
   logic [NL-1:0][CW-1:0]     threshold_i;
   logic [NL-1:0]             hit_clr_i;
   logic [NL-1:0]             hit_o;
   logic [NL-1:0]             sat_o;
   logic                      rd_req_i;
   logic [LW-1:0]             rd_lane_i;
   logic                      rd_clear_i;
   logic                      rd_valid_o;
   logic [CW-1:0]             rd_data_o;
   logic                      rd_err_o;

   always #5 clk_i = ~clk_i;

   rm_lane_accumulator #(.NUM_LANES(NL), .NUM_EVENTS(NE), .CNT_WIDTH(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .lane_vector_i(lane_vector_i),
      .lane_reset_i(lane_reset_i), .threshold_i(threshold_i), .hit_clr_i(hit_clr_i),
      .hit_o(hit_o), .sat_o(sat_o), .rd_req_i(rd_req_i), .rd_lane_i(rd_lane_i),
      .rd_clear_i(rd_clear_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
      .rd_err_o(rd_err_o)
   );

   typedef struct {
      logic [CW-1:0] data;
      logic          err;
   } rsp_t;

   rsp_t sb_q[$];
   int   cnt_m[NL];
   bit   hit_m[NL];
   bit   sat_m[NL];
   int   pinc_m[NL];
   bit   prst_m[NL];
   bit   last_rst_m = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: advance one clock edge using the inputs currently applied.
   task automatic model_step();
      int old_v, new_v, thr;
      bit clr;
      last_rst_m = rst_i;
      if (rst_i) begin
         for (int l = 0; l < NL; l++) begin
            cnt_m[l] = 0; hit_m[l] = 0; sat_m[l] = 0; pinc_m[l] = 0; prst_m[l] = 0;
         end
         sb_q.delete();
      end else begin
         if (rd_req_i) begin
            rsp_t r;
            r.err  = (int'(rd_lane_i) >= NL);
            r.data = r.err ? 8'd0 : CW'(cnt_m[int'(rd_lane_i)]);
            sb_q.push_back(r);
         end
         for (int l = 0; l < NL; l++) begin
            old_v = cnt_m[l];
            thr   = int'(threshold_i[l]);
            clr   = rd_req_i && rd_clear_i && (int'(rd_lane_i) == l);
            if (prst_m[l]) begin
               cnt_m[l] = 0; hit_m[l] = 0; sat_m[l] = 0;
            end else begin
               if (clr) begin
                  new_v = pinc_m[l];
                  sat_m[l] = 0;
               end else if (old_v + pinc_m[l] > CMAX) begin
                  new_v = CMAX;
                  sat_m[l] = 1;
               end else begin
                  new_v = old_v + pinc_m[l];
               end
               if (thr != 0 && old_v < thr && new_v >= thr) hit_m[l] = 1;
               else if (hit_clr_i[l]) hit_m[l] = 0;
               cnt_m[l] = new_v;
            end
            pinc_m[l] = 0;
            if (en_i) for (int e = 0; e < NE; e++) pinc_m[l] += int'(lane_vector_i[e][l]);
            prst_m[l] = lane_reset_i[l];
         end
      end
   endtask

   task automatic step();
      @(negedge clk_i); #1;
      model_step();
      @(posedge clk_i); #1;
   endtask

   task automatic idle_inputs();
      en_i = 1'b1; lane_vector_i = '0; lane_reset_i = '0; hit_clr_i = '0;
      rd_req_i = 1'b0; rd_lane_i = '0; rd_clear_i = 1'b0;
   endtask

   task automatic add_events(input int lane, input int n);
      for (int e = 0; e < n; e++) lane_vector_i[e][lane] = 1'b1;
   endtask

   task automatic read_lane(input int lane, input bit clr);
      rd_req_i = 1'b1; rd_lane_i = LW'(lane); rd_clear_i = clr;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) begin idle_inputs(); step(); end
   endtask

   task automatic read_all();
      for (int l = 0; l < NL; l++) begin idle_inputs(); read_lane(l, 1'b0); step(); end
      idle_steps(1);
   endtask

   // Monitor: pops the scoreboard whenever a response is due and checks sticky flags.
   always @(negedge clk_i) begin
      bit   exp_v;
      rsp_t r;
      logic [NL-1:0] eh, es;
      exp_v = (sb_q.size() != 0);
      n_cmp++;
      if (rd_valid_o !== exp_v) begin
         n_bad++; $display("FAIL rd_valid: got %b want %b t=%0t", rd_valid_o, exp_v, $time);
      end
      if (exp_v) begin
         r = sb_q.pop_front();
         n_cmp++;
         if (rd_data_o !== r.data || rd_err_o !== r.err) begin
            n_bad++;
            $display("FAIL rd_data: got %0d err %b want %0d err %b t=%0t",
                     rd_data_o, rd_err_o, r.data, r.err, $time);
         end
      end else if (last_rst_m) begin
         n_cmp++;
         if (rd_data_o !== 8'd0 || rd_err_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_rd: got %0d err %b want 0 err 0", rd_data_o, rd_err_o);
         end
      end
      for (int l = 0; l < NL; l++) begin eh[l] = hit_m[l]; es[l] = sat_m[l]; end
      n_cmp++;
      if (hit_o !== eh) begin
         n_bad++; $display("FAIL hit_o: got %b want %b t=%0t", hit_o, eh, $time);
      end
      n_cmp++;
      if (sat_o !== es) begin
         n_bad++; $display("FAIL sat_o: got %b want %b t=%0t", sat_o, es, $time);
      end
   end

   initial begin
      idle_inputs();
      threshold_i = '0;
      rst_i = 1'b1;
      step(); step();
      rst_i = 1'b0;

      // All-ones on lane 2 for three cycles -> 30.
      for (int i = 0; i < 3; i++) begin idle_inputs(); add_events(2, NE); step(); end
      idle_steps(2);
      read_all();

      // Threshold crossing on lane 1, then clear while counting past it.
      threshold_i[1] = 8'd15;
      for (int i = 0; i < 3; i++) begin idle_inputs(); add_events(1, 8); step(); end
      idle_steps(2);
      for (int i = 0; i < 2; i++) begin
         idle_inputs(); add_events(1, 8); hit_clr_i[1] = 1'b1; step();
      end
      idle_steps(2);
      idle_inputs(); read_lane(1, 1'b0); step();

      // Lane 3 reset together with in-flight events.
      for (int i = 0; i < 4; i++) begin idle_inputs(); add_events(3, NE); step(); end
      idle_steps(2);
      idle_inputs(); add_events(3, 5); lane_reset_i[3] = 1'b1; step();
      idle_steps(3);
      idle_inputs(); read_lane(3, 1'b0); step();

      // Saturate lane 4, then clear-on-read absorbing an in-flight increment.
      for (int i = 0; i < 26; i++) begin idle_inputs(); add_events(4, NE); step(); end
      idle_steps(2);
      idle_inputs(); add_events(4, 3); step();
      idle_inputs(); read_lane(4, 1'b1); step();
      idle_inputs(); read_lane(4, 1'b0); step();

      // Out-of-range lanes touch nothing.
      idle_inputs(); read_lane(NL, 1'b1); step();
      idle_inputs(); read_lane(7, 1'b1); step();
      read_all();

      // Enable low: only the lane reset takes effect.
      idle_inputs(); en_i = 1'b0; lane_vector_i = '1; lane_reset_i[0] = 1'b1; step();
      idle_steps(3);
      read_all();

      // Random traffic.
      for (int l = 0; l < NL; l++) threshold_i[l] = ($urandom_range(0, 3) == 0) ? 8'd0 : CW'($urandom_range(1, 255));
      for (int i = 0; i < 800; i++) begin
         idle_inputs();
         en_i = ($urandom_range(0, 9) < 8);
         for (int e = 0; e < NE; e++)
            for (int l = 0; l < NL; l++) lane_vector_i[e][l] = ($urandom_range(0, 9) < 3);
         for (int l = 0; l < NL; l++) begin
            lane_reset_i[l] = ($urandom_range(0, 39) == 0);
            hit_clr_i[l]    = ($urandom_range(0, 9) == 0);
         end
         rd_req_i   = $urandom_range(0, 1);
         rd_lane_i  = LW'($urandom_range(0, 7));
         rd_clear_i = ($urandom_range(0, 9) < 3);
         rst_i      = ($urandom_range(0, 149) == 0);
         if (i % 200 == 199)
            for (int l = 0; l < NL; l++) threshold_i[l] = CW'($urandom_range(0, 255));
         step();
      end
      rst_i = 1'b0;
      idle_steps(3);
      read_all();
      idle_steps(2);

      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++; $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
